// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, widths and flag indices for the floating-point divider
package fp_pkg;

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } cls_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_ITER,
        ST_MUL,
        ST_NORM,
        ST_DONE
    } state_t;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_DIV_ZERO  = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - unpack a packed float, flush subnormals, classify it
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] val,
    output logic                 sign,
    output logic [EXP_W-1:0]     exponent,
    output logic [MAN_W-1:0]     mantissa,
    output logic [1:0]           cls
);

    // Subnormals collapse to a signed zero so the divider only ever sees 1.m operands.
    always_comb begin
        sign     = val[EXP_W+MAN_W];
        exponent = val[EXP_W+MAN_W-1:MAN_W];
        mantissa = val[MAN_W-1:0];
        cls      = CLS_NORMAL;
        if (exponent == '0) begin
            mantissa = '0;
            cls      = CLS_ZERO;
        end else if (exponent == '1) begin
            cls = (mantissa == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_div_nr.sv
// rtl/fp_div_nr.sv - multi-cycle Newton-Raphson reciprocal floating-point divider
module fp_div_nr
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int ITERS = 3,
    parameter int GUARD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] num,
    input  logic [EXP_W+MAN_W:0] den,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] quo,
    output logic [3:0]           flags
);

    localparam int W    = fp_width(EXP_W, MAN_W);
    localparam int BIAS = fp_bias(EXP_W);
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam int F    = MAN_W + GUARD;     // fraction bits of the fixed-point datapath
    localparam int XW   = F + 2;             // two integer bits: reciprocal lies in (1,2]
    localparam int PW   = 2 * XW;
    localparam int EW   = EXP_W + 2;         // signed exponent with headroom
    localparam logic [XW-1:0] C48  = XW'(((64'd48 << F) + 64'd8) / 64'd17);
    localparam logic [XW-1:0] C32  = XW'(((64'd32 << F) + 64'd8) / 64'd17);
    localparam logic [XW-1:0] TWO  = {2'b10, {F{1'b0}}};
    localparam logic [2:0]    LAST = 3'(ITERS - 1);

    state_t                state, state_nxt;
    logic [2:0]            cnt;
    logic                  n_sign, d_sign, sign_r, special;
    logic [EXP_W-1:0]      n_exp, d_exp;
    logic [MAN_W-1:0]      n_man, d_man, n_man_r, d_man_r;
    logic [1:0]            n_cls, d_cls;
    logic signed [EW-1:0]  exp_base, exp_fin;
    logic [F-1:0]          d_fx;
    logic [XW-1:0]         x, p, mul_a, mul_b, mul_q, dx, two_minus;
    logic [W-1:0]          sp_quo, nq;
    logic [3:0]            sp_flags, nf;
    logic                  hi, grd, stk;
    logic [MAN_W-1:0]      frac;
    logic [MAN_W:0]        man_rnd;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_num (
        .val(num), .sign(n_sign), .exponent(n_exp), .mantissa(n_man), .cls(n_cls)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_den (
        .val(den), .sign(d_sign), .exponent(d_exp), .mantissa(d_man), .cls(d_cls)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign d_fx      = {1'b1, d_man_r, {(GUARD-1){1'b0}}};   // 0.1m, i.e. D in [0.5,1)

    // Special-operand results, resolved in the accept cycle without touching the datapath.
    always_comb begin
        special  = (n_cls != CLS_NORMAL) || (d_cls != CLS_NORMAL);
        sp_quo   = {n_sign ^ d_sign, {(W-1){1'b0}}};
        sp_flags = '0;
        if (n_cls == CLS_NAN || d_cls == CLS_NAN ||
            (n_cls == CLS_ZERO && d_cls == CLS_ZERO) ||
            (n_cls == CLS_INF && d_cls == CLS_INF)) begin
            sp_quo                 = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            sp_flags[FLAG_INVALID] = 1'b1;
        end else if (n_cls == CLS_INF || d_cls == CLS_ZERO) begin
            sp_quo                  = {n_sign ^ d_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            sp_flags[FLAG_DIV_ZERO] = (d_cls == CLS_ZERO) && (n_cls == CLS_NORMAL);
        end
    end

    // One shared multiplier: seed slope in SEED, refinement in ITER, num*recip in MUL.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_SEED: begin mul_a = C32;  mul_b = XW'(d_fx); end
            ST_ITER: begin mul_a = x;    mul_b = two_minus; end
            ST_MUL:  begin mul_a = XW'({1'b1, n_man_r, {GUARD{1'b0}}}); mul_b = x; end
            default: ;
        endcase
    end

    assign mul_q     = XW'((PW'(mul_a) * PW'(mul_b)) >> F);
    assign dx        = XW'((PW'(d_fx) * PW'(x)) >> F);
    assign two_minus = TWO - dx;

    // Normalise num*recip (in [1,4)) by at most one bit, round to nearest-even, range-check.
    always_comb begin
        hi = p[XW-1];
        if (hi) begin
            frac = p[XW-2 -: MAN_W];
            grd  = p[XW-2-MAN_W];
            stk  = |p[XW-3-MAN_W:0];
        end else begin
            frac = p[XW-3 -: MAN_W];
            grd  = p[XW-3-MAN_W];
            stk  = |p[XW-4-MAN_W:0];
        end
        man_rnd = {1'b0, frac} + (MAN_W+1)'(grd & (stk | frac[0]));
        exp_fin = exp_base - EW'(!hi) + EW'(man_rnd[MAN_W]);
        nq      = {sign_r, exp_fin[EXP_W-1:0], man_rnd[MAN_W-1:0]};
        nf      = '0;
        if (int'(exp_fin) >= EMAX) begin
            nq                = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            nf[FLAG_OVERFLOW] = 1'b1;
        end else if (int'(exp_fin) <= 0) begin
            nq                 = {sign_r, {(W-1){1'b0}}};
            nf[FLAG_UNDERFLOW] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = special ? ST_DONE : ST_SEED;
            ST_SEED: state_nxt = ST_ITER;
            ST_ITER: if (cnt == LAST) state_nxt = ST_MUL;
            ST_MUL:  state_nxt = ST_NORM;
            ST_NORM: state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_ITER) cnt <= (cnt == LAST) ? 3'd0 : cnt + 3'd1;
        end
    end

    // Datapath registers; quo/flags only change on a special accept or in NORM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_man_r  <= '0;
            d_man_r  <= '0;
            sign_r   <= 1'b0;
            exp_base <= '0;
            x        <= '0;
            p        <= '0;
            quo      <= '0;
            flags    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    n_man_r  <= n_man;
                    d_man_r  <= d_man;
                    sign_r   <= n_sign ^ d_sign;
                    exp_base <= EW'(n_exp) - EW'(d_exp) + EW'(BIAS);
                    if (special) begin
                        quo   <= sp_quo;
                        flags <= sp_flags;
                    end
                end
                ST_SEED: x <= C48 - mul_q;
                ST_ITER: x <= mul_q;
                ST_MUL:  p <= mul_q;
                ST_NORM: begin
                    quo   <= nq;
                    flags <= nf;
                end
                default: ;
            endcase
        end
    end

endmodule
